// File: rtl/i2s_apb4_dma.sv
// i2s_apb4_dma: APB4 initiator moving samples between stream ports and the I2S controller TX/RX FIFOs.
// Define I2S_DMA_POLL_EN to add a periodic STAT poll that recovers data below the controller IRQ thresholds.
module i2s_apb4_dma #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] TXR_OFS     = 32'h8,
  parameter logic [31:0] RXR_OFS     = 32'hC,
  parameter logic [31:0] STAT_OFS    = 32'h10,
  parameter int          POLL_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        irq_i,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  output logic [2:0]  pprot_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, STAT_S, STAT_A, RX_S, RX_A, TX_S, TX_A} state_t;

  state_t state, state_nxt;
  logic   tx_full_q, rx_pend, en_q, poll_tick;
  logic   xfer_done, xfer_err;

  assign xfer_done = penable_o && pready_i;
  assign xfer_err  = xfer_done && pslverr_i;

  // Each STAT read licenses at most one RX pop and one TX push.
  always_comb begin
    state_nxt  = state;
    psel_o     = (state != IDLE);
    penable_o  = (state == STAT_A) || (state == RX_A) || (state == TX_A);
    tx_ready_o = (state == TX_S);
    pprot_o    = 3'b000;
    unique case (state)
      IDLE: begin
        if (en_i && (irq_i || (tx_valid_i && !tx_full_q) || (rx_pend && !rx_valid_o) || poll_tick))
          state_nxt = STAT_S;
      end
      STAT_S: state_nxt = STAT_A;
      STAT_A: begin
        if (pready_i) begin
          if (pslverr_i || !en_i)                state_nxt = IDLE;
          else if (!prdata_i[4] && !rx_valid_o)  state_nxt = RX_S;
          else if (!prdata_i[3] && tx_valid_i)   state_nxt = TX_S;
          else                                   state_nxt = IDLE;
        end
      end
      RX_S: state_nxt = RX_A;
      RX_A: begin
        if (pready_i) begin
          if (pslverr_i || !en_i)              state_nxt = IDLE;
          else if (!tx_full_q && tx_valid_i)   state_nxt = TX_S;
          else                                 state_nxt = STAT_S;
        end
      end
      TX_S: state_nxt = TX_A;
      TX_A: begin
        if (pready_i) state_nxt = (pslverr_i || !en_i) ? IDLE : STAT_S;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Address/control are loaded on entry to setup so they hold steady through the access phase.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
      pstrb_o  <= 4'h0;
    end else if (state_nxt != state) begin
      if (state_nxt == STAT_S) begin
        paddr_o  <= BASE_ADDR + STAT_OFS;
        pwrite_o <= 1'b0;
        pstrb_o  <= 4'h0;
      end else if (state_nxt == RX_S) begin
        paddr_o  <= BASE_ADDR + RXR_OFS;
        pwrite_o <= 1'b0;
        pstrb_o  <= 4'h0;
      end else if (state_nxt == TX_S) begin
        paddr_o  <= BASE_ADDR + TXR_OFS;
        pwrite_o <= 1'b1;
        pstrb_o  <= 4'hF;
        pwdata_o <= tx_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_full_q  <= 1'b0;
      rx_pend    <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      err_o      <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      en_q <= en_i;
      if (state == STAT_A && xfer_done && !pslverr_i) begin
        tx_full_q <= prdata_i[3];
        rx_pend   <= ~prdata_i[4];
      end
      if (state == RX_A && xfer_done && !pslverr_i) begin
        rx_data_o  <= prdata_i;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (xfer_err)             err_o <= 1'b1;
      else if (en_i && !en_q)   err_o <= 1'b0;
    end
  end

`ifdef I2S_DMA_POLL_EN
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  logic [PW-1:0] poll_cnt;
  logic          poll_pend;

  // The tick stays pending until IDLE actually launches a STAT read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_cnt  <= '0;
      poll_pend <= 1'b0;
    end else begin
      if (!en_i)                                 poll_cnt <= '0;
      else if (poll_cnt == PW'(POLL_CYCLES - 1)) poll_cnt <= '0;
      else                                       poll_cnt <= poll_cnt + 1'b1;
      if (en_i && poll_cnt == PW'(POLL_CYCLES - 1))  poll_pend <= 1'b1;
      else if (state == IDLE && state_nxt == STAT_S) poll_pend <= 1'b0;
    end
  end

  assign poll_tick = poll_pend;
`else
  assign poll_tick = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_apb4_dma.sv
// tb_i2s_apb4_dma: directed bench with a small I2S-controller APB responder model.
// Covers IRQ-driven RX, TX bursts, RX backpressure, wait states, bus errors, async reset and polling.
module tb_i2s_apb4_dma;

  logic        clk_i, rst_i, en_i, irq_i;
  logic [31:0] paddr_o, pwdata_o, prdata_i, tx_data_i, rx_data_o;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
  logic [3:0]  pstrb_o;
  logic [2:0]  pprot_o;
  logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, err_o;

  int checks, errors;

  // Responder model state
  logic        tx_full_m;
  logic [31:0] rx_words [0:31];
  logic [31:0] tx_words [0:31];
  int          rx_pushed, rx_popped, tx_cnt, tx_idx, tx_hs;
  int          tx_waits, rx_waits, wait_cnt, cyc;
  bit          err_rx;
  logic [31:0] stat_word;
  logic        acc;
  int          cur_waits;

  logic [31:0] log_addr [$];
  bit          log_wr   [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_strb [$];
  int          log_cyc  [$];
  logic [31:0] rx_got   [$];

  i2s_apb4_dma #(.POLL_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .irq_i(irq_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    stat_word  = {27'b0, (rx_pushed == rx_popped), tx_full_m, 3'b000};
    prdata_i   = (paddr_o == 32'h10) ? stat_word : rx_words[rx_popped[4:0]];
    acc        = psel_o && penable_o;
    cur_waits  = pwrite_o ? tx_waits : ((paddr_o == 32'hC) ? rx_waits : 0);
    pready_i   = !acc || (wait_cnt >= cur_waits);
    pslverr_i  = acc && pready_i && err_rx && !pwrite_o && (paddr_o == 32'hC);
    tx_valid_i = (tx_idx < tx_cnt);
    tx_data_i  = tx_words[tx_idx[4:0]];
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (!acc || pready_i) wait_cnt <= 0;
    else                  wait_cnt <= wait_cnt + 1;
    if (acc && pready_i) begin
      log_addr.push_back(paddr_o);
      log_wr.push_back(pwrite_o);
      log_data.push_back(pwdata_o);
      log_strb.push_back(pstrb_o);
      log_cyc.push_back(cyc);
      if (!pwrite_o && paddr_o == 32'hC && !pslverr_i) rx_popped <= rx_popped + 1;
    end
    if (tx_valid_i && tx_ready_o) begin
      tx_hs  <= tx_hs + 1;
      tx_idx <= tx_idx + 1;
    end
    if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
  end

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (log_addr.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic pulse_irq();
    @(negedge clk_i);
    irq_i = 1'b1;
    @(negedge clk_i);
    irq_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if ({psel_o, penable_o, pwrite_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctrl: got %b, want 000", {psel_o, penable_o, pwrite_o}); end
    checks++; if ({tx_ready_o, rx_valid_o, err_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b, want 000", {tx_ready_o, rx_valid_o, err_o}); end
    checks++; if ({paddr_o, pwdata_o, rx_data_o} !== 96'h0) begin errors++; $display("[TB] FAIL reset_data: got %h, want 0", {paddr_o, pwdata_o, rx_data_o}); end
    checks++; if ({pstrb_o, pprot_o} !== 7'h0) begin errors++; $display("[TB] FAIL reset_strb_prot: got %h, want 0", {pstrb_o, pprot_o}); end
    rst_i = 1'b0;
    en_i  = 1'b1;
    repeat (4) @(negedge clk_i);
    checks++; if (log_addr.size() !== 0 || psel_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: got %0d transfers, want 0", log_addr.size()); end
  endtask

  task automatic test_irq_rx();
    int base; bit ok;
    base = log_addr.size();
    tx_full_m = 1'b1;
    rx_words[rx_pushed[4:0]] = 32'hA5A5_0000; rx_pushed++;
    pulse_irq();
    checks++; if ({psel_o, penable_o} !== 2'b10 || paddr_o !== 32'h10) begin errors++; $display("[TB] FAIL irq_stat_setup: got sel/en %b addr %h, want 10 addr 00000010", {psel_o, penable_o}, paddr_o); end
    @(negedge clk_i);
    checks++; if ({psel_o, penable_o} !== 2'b11) begin errors++; $display("[TB] FAIL irq_stat_access: got %b, want 11", {psel_o, penable_o}); end
    wait_log(base + 3, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL irq_timeout: got %0d transfers, want %0d", log_addr.size() - base, 3); end
    if (ok) begin
      checks++; if (log_addr[base] !== 32'h10 || log_wr[base] !== 1'b0) begin errors++; $display("[TB] FAIL irq_first_stat: got addr %h wr %b, want 00000010 0", log_addr[base], log_wr[base]); end
      checks++; if (log_addr[base+1] !== 32'hC || log_wr[base+1] !== 1'b0 || log_strb[base+1] !== 4'h0) begin errors++; $display("[TB] FAIL irq_rxr_read: got addr %h wr %b strb %h, want 0000000c 0 0", log_addr[base+1], log_wr[base+1], log_strb[base+1]); end
      checks++; if (log_addr[base+2] !== 32'h10) begin errors++; $display("[TB] FAIL irq_second_stat: got %h, want 00000010", log_addr[base+2]); end
    end
    repeat (6) @(negedge clk_i);
    checks++; if (log_addr.size() !== base + 3 || psel_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_back_idle: got %0d transfers, want %0d", log_addr.size() - base, 3); end
    checks++; if (rx_got.size() !== 1) begin errors++; $display("[TB] FAIL irq_rx_count: got %0d, want 1", rx_got.size()); end
    else begin
      checks++; if (rx_got[0] !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL irq_rx_data: got %h, want a5a50000", rx_got[0]); end
    end
  endtask

  task automatic test_tx_burst();
    int base, hs0; bit ok;
    logic [31:0] exp_tx [0:2];
    exp_tx[0] = 32'h1111_0001; exp_tx[1] = 32'h2222_0002; exp_tx[2] = 32'h3333_0003;
    base = log_addr.size();
    hs0  = tx_hs;
    @(negedge clk_i);
    tx_full_m = 1'b0;
    for (int k = 0; k < 3; k++) tx_words[tx_cnt + k] = exp_tx[k];
    tx_cnt = tx_cnt + 3;
    pulse_irq();
    wait_log(base + 7, 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL tx_timeout: got %0d transfers, want 7", log_addr.size() - base); end
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (log_addr[base+2*k] !== 32'h10 || log_wr[base+2*k] !== 1'b0) begin errors++; $display("[TB] FAIL tx_stat_%0d: got addr %h wr %b, want 00000010 0", k, log_addr[base+2*k], log_wr[base+2*k]); end
        checks++; if (log_addr[base+2*k+1] !== 32'h8 || log_wr[base+2*k+1] !== 1'b1 || log_strb[base+2*k+1] !== 4'hF) begin errors++; $display("[TB] FAIL tx_write_%0d: got addr %h wr %b strb %h, want 00000008 1 f", k, log_addr[base+2*k+1], log_wr[base+2*k+1], log_strb[base+2*k+1]); end
        checks++; if (log_data[base+2*k+1] !== exp_tx[k]) begin errors++; $display("[TB] FAIL tx_data_%0d: got %h, want %h", k, log_data[base+2*k+1], exp_tx[k]); end
      end
    end
    repeat (5) @(negedge clk_i);
    checks++; if (tx_hs - hs0 !== 3) begin errors++; $display("[TB] FAIL tx_ready_pulses: got %0d, want 3", tx_hs - hs0); end
    checks++; if (log_addr.size() !== base + 7) begin errors++; $display("[TB] FAIL tx_extra_transfers: got %0d, want 7", log_addr.size() - base); end
  endtask

  task automatic test_rx_backpressure();
    int base; bit ok;
    base = log_addr.size();
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    rx_words[rx_pushed[4:0]] = 32'h1111_2222; rx_pushed++;
    rx_words[rx_pushed[4:0]] = 32'h3333_4444; rx_pushed++;
    pulse_irq();
    wait_log(base + 3, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: got %0d transfers, want 3", log_addr.size() - base); end
    repeat (10) @(negedge clk_i);
    checks++; if (log_addr.size() !== base + 3) begin errors++; $display("[TB] FAIL bp_no_read_while_full: got %0d transfers, want 3", log_addr.size() - base); end
    checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 32'h1111_2222) begin errors++; $display("[TB] FAIL bp_held_word: got valid %b data %h, want 1 11112222", rx_valid_o, rx_data_o); end
    rx_ready_i = 1'b1;
    wait_log(base + 6, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_retrigger_timeout: got %0d transfers, want 6", log_addr.size() - base); end
    if (ok) begin
      checks++; if (log_addr[base+3] !== 32'h10 || log_addr[base+4] !== 32'hC) begin errors++; $display("[TB] FAIL bp_retrigger_seq: got %h %h, want 00000010 0000000c", log_addr[base+3], log_addr[base+4]); end
    end
    repeat (5) @(negedge clk_i);
    checks++; if (rx_got.size() !== 3) begin errors++; $display("[TB] FAIL bp_rx_count: got %0d, want 3", rx_got.size()); end
    else begin
      checks++; if (rx_got[1] !== 32'h1111_2222 || rx_got[2] !== 32'h3333_4444) begin errors++; $display("[TB] FAIL bp_rx_order: got %h %h, want 11112222 33334444", rx_got[1], rx_got[2]); end
    end
  endtask

  task automatic test_wait_states();
    int base; bit ok, seen;
    base = log_addr.size();
    @(negedge clk_i);
    tx_waits = 5;
    tx_words[tx_cnt] = 32'hDEAD_BEEF; tx_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (penable_o && pwrite_o) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL ws_no_tx_access: got 0, want 1"); end
    if (seen) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk_i);
        checks++; if ({psel_o, penable_o} !== 2'b11 || pwdata_o !== 32'hDEAD_BEEF || paddr_o !== 32'h8) begin errors++; $display("[TB] FAIL ws_stable_%0d: got sel/en %b data %h addr %h, want 11 deadbeef 00000008", i, {psel_o, penable_o}, pwdata_o, paddr_o); end
      end
      @(negedge clk_i);
      checks++; if (penable_o !== 1'b0 || paddr_o !== 32'h10) begin errors++; $display("[TB] FAIL ws_complete: got en %b addr %h, want 0 00000010", penable_o, paddr_o); end
    end
    tx_waits = 0;
    wait_log(base + 3, 40, ok);
    checks++; if (!ok || log_data[base+1] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ws_logged_write: got %0d transfers, want 3 with deadbeef", log_addr.size() - base); end
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_error();
    int base; bit ok;
    base = log_addr.size();
    @(negedge clk_i);
    err_rx = 1'b1;
    rx_words[rx_pushed[4:0]] = 32'hEEEE_0001; rx_pushed++;
    pulse_irq();
    wait_log(base + 2, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL err_timeout: got %0d transfers, want 2", log_addr.size() - base); end
    checks++; if (psel_o !== 1'b0 || err_o !== 1'b1 || rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL err_response: got sel %b err %b rxv %b, want 0 1 0", psel_o, err_o, rx_valid_o); end
    en_i = 1'b0;
    repeat (5) @(negedge clk_i);
    checks++; if (err_o !== 1'b1 || rx_got.size() !== 3 || log_addr.size() !== base + 2) begin errors++; $display("[TB] FAIL err_sticky: got err %b rx %0d xfers %0d, want 1 3 2", err_o, rx_got.size(), log_addr.size() - base); end
    err_rx   = 1'b0;
    rx_waits = 3;
    en_i     = 1'b1;
    @(negedge clk_i);
    checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL err_clear_on_enable: got %b, want 0", err_o); end
  endtask

  task automatic test_reset_mid_access();
    int base; bit ok, seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (penable_o && paddr_o == 32'hC) seen = 1'b1;
      else @(negedge clk_i);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL rst_no_rx_access: got 0, want 1"); end
    rst_i = 1'b1;
    #1;
    checks++; if ({psel_o, penable_o} !== 2'b00) begin errors++; $display("[TB] FAIL rst_async_drop: got %b, want 00", {psel_o, penable_o}); end
    checks++; if ({paddr_o, pwdata_o, rx_data_o} !== 96'h0 || {pwrite_o, pstrb_o, pprot_o} !== 8'h0) begin errors++; $display("[TB] FAIL rst_async_regs: got %h, want 0", {paddr_o, pwdata_o, rx_data_o}); end
    checks++; if ({tx_ready_o, rx_valid_o, err_o} !== 3'b000) begin errors++; $display("[TB] FAIL rst_async_flags: got %b, want 000", {tx_ready_o, rx_valid_o, err_o}); end
    rx_waits = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    base = log_addr.size();
    repeat (4) @(negedge clk_i);
    checks++; if (log_addr.size() !== base) begin errors++; $display("[TB] FAIL rst_quiet_after_release: got %0d transfers, want 0", log_addr.size() - base); end
    pulse_irq();
    wait_log(base + 3, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_restart_timeout: got %0d transfers, want 3", log_addr.size() - base); end
    else begin
      checks++; if (log_addr[base] !== 32'h10 || log_addr[base+1] !== 32'hC || log_addr[base+2] !== 32'h10) begin errors++; $display("[TB] FAIL rst_restart_seq: got %h %h %h, want 00000010 0000000c 00000010", log_addr[base], log_addr[base+1], log_addr[base+2]); end
    end
    repeat (4) @(negedge clk_i);
    checks++; if (rx_got.size() !== 4) begin errors++; $display("[TB] FAIL rst_restart_rx_count: got %0d, want 4", rx_got.size()); end
    else begin
      checks++; if (rx_got[3] !== 32'hEEEE_0001) begin errors++; $display("[TB] FAIL rst_restart_rx_data: got %h, want eeee0001", rx_got[3]); end
    end
  endtask

  task automatic test_poll();
    int base;
`ifdef I2S_DMA_POLL_EN
    bit ok;
`endif
    @(negedge clk_i);
    tx_full_m = 1'b1;
    repeat (20) @(negedge clk_i);
    base = log_addr.size();
`ifdef I2S_DMA_POLL_EN
    wait_log(base + 5, 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL poll_timeout: got %0d transfers, want 5", log_addr.size() - base); end
    else begin
      for (int k = 1; k < 5; k++) begin
        checks++; if (log_cyc[base+k] - log_cyc[base+k-1] !== 16 || log_addr[base+k] !== 32'h10) begin errors++; $display("[TB] FAIL poll_period_%0d: got %0d cycles addr %h, want 16 00000010", k, log_cyc[base+k] - log_cyc[base+k-1], log_addr[base+k]); end
      end
    end
`else
    repeat (200) @(negedge clk_i);
    checks++; if (log_addr.size() !== base) begin errors++; $display("[TB] FAIL poll_disabled: got %0d transfers, want 0", log_addr.size() - base); end
`endif
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    rst_i = 1'b1; en_i = 1'b0; irq_i = 1'b0; rx_ready_i = 1'b1;
    tx_full_m = 1'b0; err_rx = 1'b0;
    rx_pushed = 0; rx_popped = 0; tx_cnt = 0; tx_idx = 0; tx_hs = 0;
    tx_waits = 0; rx_waits = 0; wait_cnt = 0; cyc = 0;
    for (int i = 0; i < 32; i++) begin
      rx_words[i] = '0;
      tx_words[i] = '0;
    end
    test_reset();
    test_irq_rx();
    test_tx_burst();
    test_rx_backpressure();
    test_wait_states();
    test_error();
    test_reset_mid_access();
    test_poll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
